match_peak_finder: RTL and testbench

//   Downstream of score_cal. Consumes one candidate score per valid cycle, in raster order over a

---
 rtl/match_peak_finder.sv | 157 +++++++++++++++
 tb/tb_match_peak_finder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/match_peak_finder.sv
// Match decision stage: tracks the best candidate score and its raster position within a frame,
// then reports the peak, candidate count and threshold hit for one cycle once the frame closes.
module match_peak_finder #(
  parameter int WIDTH    = 8,
  parameter int LINE_LEN = 640,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int MAX_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 score_valid,
  input  logic [WIDTH+12:0]    score,
  input  logic [WIDTH+12:0]    threshold,
  output logic                 best_valid,
  output logic [WIDTH+12:0]    best_score,
  output logic [XW-1:0]        best_x,
  output logic [YW-1:0]        best_y,
  output logic                 hit,
  output logic [XW+YW-1:0]     cand_count,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int SW = WIDTH + 13;
  localparam int CW = XW + YW;
  localparam logic [XW-1:0] XLAST = XW'(LINE_LEN - 1);
  // Value reported for a frame that saw no candidates.
  localparam logic [SW-1:0] EMPTY = (MAX_MODE != 0) ? {SW{1'b0}} : {SW{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Handshake: inputs are single-cycle qualifiers sampled on every rising edge; best_valid is a
  // one-cycle pulse and best_*/hit/cand_count are meaningful (and held) from that cycle onward.
  state_t state, state_next;

  logic [SW-1:0] run_best;
  logic [XW-1:0] run_bx, pos_x;
  logic [YW-1:0] run_by, pos_y;
  logic [CW-1:0] run_count;
  logic          first_r;
  logic          hit_r;

  logic          start_new, take, first_eff, improves, better, hit_now;
  logic [SW-1:0] best_base, n_best;
  logic [XW-1:0] bx_base, px_base, n_bx, n_px;
  logic [YW-1:0] by_base, py_base, n_by, n_py;
  logic [CW-1:0] cnt_base, n_count;
  logic          n_first;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = SCAN;
      SCAN:    if (frame_end) state_next = REPORT;
      REPORT:  state_next = frame_start ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    best_valid = (state == REPORT);
    busy       = (state == SCAN);
    dbg_state  = state;
    hit        = (state == REPORT) ? hit_now : hit_r;
  end

  // A new frame begins on frame_start unless it collides with frame_end inside SCAN.
  always_comb begin
    start_new = frame_start && !(state == SCAN && frame_end);
    take      = score_valid && (start_new || state == SCAN);
    first_eff = start_new ? 1'b1 : first_r;
    best_base = start_new ? EMPTY : run_best;
    bx_base   = start_new ? '0 : run_bx;
    by_base   = start_new ? '0 : run_by;
    px_base   = start_new ? '0 : pos_x;
    py_base   = start_new ? '0 : pos_y;
    cnt_base  = start_new ? '0 : run_count;
    improves  = (MAX_MODE != 0) ? (score > best_base) : (score < best_base);
    better    = first_eff || improves;
  end

  always_comb begin
    n_best  = best_base;
    n_bx    = bx_base;
    n_by    = by_base;
    n_px    = px_base;
    n_py    = py_base;
    n_count = cnt_base;
    n_first = first_eff;
    if (take) begin
      n_first = 1'b0;
      if (better) begin
        n_best = score;
        n_bx   = px_base;
        n_by   = py_base;
      end
      if (px_base == XLAST) begin
        n_px = '0;
        n_py = py_base + 1'b1;
      end else begin
        n_px = px_base + 1'b1;
      end
      if (cnt_base != {CW{1'b1}}) n_count = cnt_base + 1'b1;
    end
  end

  always_comb begin
    if (MAX_MODE != 0) hit_now = (best_score >= threshold);
    else               hit_now = (best_score <= threshold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_best   <= '0;
      run_bx     <= '0;
      run_by     <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      run_count  <= '0;
      first_r    <= 1'b1;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
      cand_count <= '0;
      hit_r      <= 1'b0;
    end else begin
      run_best  <= n_best;
      run_bx    <= n_bx;
      run_by    <= n_by;
      pos_x     <= n_px;
      pos_y     <= n_py;
      run_count <= n_count;
      first_r   <= n_first;
      // Published values change on entry to REPORT so they are valid during the pulse.
      if (state == SCAN && frame_end) begin
        best_score <= n_best;
        best_x     <= n_bx;
        best_y     <= n_by;
        cand_count <= n_count;
      end
      if (state == REPORT) hit_r <= hit_now;
    end
  end

endmodule

// File: tb/tb_match_peak_finder.sv
// Directed bench for match_peak_finder: a MAX_MODE=1 and a MAX_MODE=0 instance share stimulus,
// each scenario task checks its own hand-computed results.
module tb_match_peak_finder;

  logic        clk, rst, frame_start, frame_end, score_valid;
  logic [20:0] score, threshold;
  logic        best_valid, hit, busy;
  logic [20:0] best_score;
  logic [9:0]  best_x, best_y;
  logic [19:0] cand_count;
  logic [1:0]  dbg_state;
  logic        mn_valid, mn_hit, mn_busy;
  logic [20:0] mn_score;
  logic [9:0]  mn_x, mn_y;
  logic [19:0] mn_count;
  logic [1:0]  mn_state;
  int total = 0;
  int bad = 0;

  match_peak_finder #(.WIDTH(8), .LINE_LEN(4), .XW(10), .YW(10), .MAX_MODE(1)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .score_valid(score_valid), .score(score), .threshold(threshold),
    .best_valid(best_valid), .best_score(best_score), .best_x(best_x), .best_y(best_y),
    .hit(hit), .cand_count(cand_count), .busy(busy), .dbg_state(dbg_state));

  match_peak_finder #(.WIDTH(8), .LINE_LEN(4), .XW(10), .YW(10), .MAX_MODE(0)) dut_min (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .score_valid(score_valid), .score(score), .threshold(threshold),
    .best_valid(mn_valid), .best_score(mn_score), .best_x(mn_x), .best_y(mn_y),
    .hit(mn_hit), .cand_count(mn_count), .busy(mn_busy), .dbg_state(mn_state));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic fs, input logic fe, input logic sv, input logic [20:0] sc);
    frame_start = fs; frame_end = fe; score_valid = sv; score = sc;
    @(posedge clk); #1;
    frame_start = 1'b0; frame_end = 1'b0; score_valid = 1'b0; score = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 0; frame_end = 0; score_valid = 0; score = '0; threshold = '0;
    repeat (2) begin @(posedge clk); #1; end
    if (best_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", best_valid); end total++;
    if (best_score !== 21'd0) begin bad++; $display("FAIL reset_score got=%0h exp=0", best_score); end total++;
    if ({best_x, best_y} !== 20'd0) begin bad++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", best_x, best_y); end total++;
    if (cand_count !== 20'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cand_count); end total++;
    if ({hit, busy} !== 2'b00) begin bad++; $display("FAIL reset_hit_busy got=%b exp=00", {hit, busy}); end total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end total++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    threshold = 21'd60;
    drive(0, 0, 1, 21'd99);
    drive(1, 0, 0, '0);
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0d exp=1", busy); end total++;
    drive(0, 0, 1, 21'd10); drive(0, 0, 1, 21'd50); drive(0, 0, 1, 21'd30);
    drive(0, 0, 1, 21'd20); drive(0, 0, 1, 21'd70);
    if (best_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0d exp=0", best_valid); end total++;
    drive(0, 1, 1, 21'd5);
    if (best_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0d exp=1", best_valid); end total++;
    if (best_score !== 21'd70) begin bad++; $display("FAIL basic_score got=%0d exp=70", best_score); end total++;
    if (best_x !== 10'd0 || best_y !== 10'd1) begin bad++; $display("FAIL basic_pos got=%0d,%0d exp=0,1", best_x, best_y); end total++;
    if (cand_count !== 20'd6) begin bad++; $display("FAIL basic_count got=%0d exp=6", cand_count); end total++;
    if (hit !== 1'b1) begin bad++; $display("FAIL basic_hit got=%0d exp=1", hit); end total++;
    drive(0, 0, 0, '0);
    if (best_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%0d exp=0", best_valid); end total++;
    if (best_score !== 21'd70 || hit !== 1'b1) begin bad++; $display("FAIL basic_hold got=%0d/%0d exp=70/1", best_score, hit); end total++;
  endtask

  task automatic test_tie_back_to_back();
    threshold = 21'd90;
    drive(1, 0, 0, '0);
    drive(0, 0, 1, 21'd40); drive(0, 0, 1, 21'd90); drive(0, 0, 1, 21'd90);
    drive(0, 1, 1, 21'd12);
    if (best_score !== 21'd90 || best_x !== 10'd1 || best_y !== 10'd0) begin bad++; $display("FAIL tie_best got=%0d@%0d,%0d exp=90@1,0", best_score, best_x, best_y); end total++;
    if (hit !== 1'b1) begin bad++; $display("FAIL tie_hit90 got=%0d exp=1", hit); end total++;
    drive(1, 0, 0, '0);
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0d exp=1", busy); end total++;
    threshold = 21'd91;
    drive(0, 0, 1, 21'd40); drive(0, 0, 1, 21'd90); drive(0, 0, 1, 21'd90);
    drive(0, 1, 1, 21'd12);
    if (best_valid !== 1'b1 || best_x !== 10'd1 || cand_count !== 20'd4) begin bad++; $display("FAIL tie2_report got=%0d/%0d/%0d exp=1/1/4", best_valid, best_x, cand_count); end total++;
    if (hit !== 1'b0) begin bad++; $display("FAIL tie_hit91 got=%0d exp=0", hit); end total++;
    drive(0, 0, 0, '0);
    threshold = 21'd0;
    #1;
    if (hit !== 1'b0) begin bad++; $display("FAIL hit_hold got=%0d exp=0", hit); end total++;
  endtask

  task automatic test_start_with_score();
    drive(1, 0, 1, 21'd3); drive(0, 0, 1, 21'd1); drive(0, 1, 1, 21'd2);
    if (best_score !== 21'd3 || best_x !== 10'd0 || best_y !== 10'd0) begin bad++; $display("FAIL sws_best got=%0d@%0d,%0d exp=3@0,0", best_score, best_x, best_y); end total++;
    if (cand_count !== 20'd3) begin bad++; $display("FAIL sws_count got=%0d exp=3", cand_count); end total++;
    drive(0, 0, 0, '0);
  endtask

  task automatic test_abort();
    drive(1, 0, 0, '0); drive(0, 0, 1, 21'd200); drive(0, 0, 1, 21'd100);
    drive(1, 0, 0, '0);
    if (best_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL abort_state got=%0d/%0d exp=0/1", best_valid, busy); end total++;
    if (best_score !== 21'd3) begin bad++; $display("FAIL abort_noreport got=%0d exp=3", best_score); end total++;
    drive(0, 0, 1, 21'd5); drive(0, 1, 1, 21'd6);
    if (best_score !== 21'd6 || best_x !== 10'd1 || best_y !== 10'd0) begin bad++; $display("FAIL abort_best got=%0d@%0d,%0d exp=6@1,0", best_score, best_x, best_y); end total++;
    if (cand_count !== 20'd2) begin bad++; $display("FAIL abort_count got=%0d exp=2", cand_count); end total++;
    drive(0, 0, 0, '0);
  endtask

  task automatic test_start_end_collision();
    drive(1, 0, 0, '0); drive(0, 0, 1, 21'd11); drive(0, 0, 1, 21'd22);
    drive(1, 1, 1, 21'd5);
    if (best_valid !== 1'b1 || best_score !== 21'd22 || best_x !== 10'd1) begin bad++; $display("FAIL coll_report got=%0d/%0d/%0d exp=1/22/1", best_valid, best_score, best_x); end total++;
    if (cand_count !== 20'd3) begin bad++; $display("FAIL coll_count got=%0d exp=3", cand_count); end total++;
    drive(0, 0, 0, '0);
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL coll_dropped got=%0d/%0d exp=0/0", busy, dbg_state); end total++;
  endtask

  task automatic test_empty_and_min();
    threshold = 21'd0;
    drive(1, 0, 0, '0); drive(0, 1, 0, '0);
    if (best_valid !== 1'b1 || best_score !== 21'd0 || cand_count !== 20'd0) begin bad++; $display("FAIL empty_max got=%0d/%0d/%0d exp=1/0/0", best_valid, best_score, cand_count); end total++;
    if (best_x !== 10'd0 || best_y !== 10'd0 || hit !== 1'b1) begin bad++; $display("FAIL empty_pos_hit got=%0d,%0d/%0d exp=0,0/1", best_x, best_y, hit); end total++;
    if (mn_score !== 21'h1FFFFF || mn_hit !== 1'b0) begin bad++; $display("FAIL empty_min got=%0h/%0d exp=1fffff/0", mn_score, mn_hit); end total++;
    threshold = 21'd5;
    drive(1, 0, 0, '0);
    drive(0, 0, 1, 21'd9); drive(0, 0, 1, 21'd4); drive(0, 1, 1, 21'd7);
    if (mn_valid !== 1'b1 || mn_score !== 21'd4 || mn_x !== 10'd1 || mn_y !== 10'd0) begin bad++; $display("FAIL min_best got=%0d/%0d@%0d,%0d exp=1/4@1,0", mn_valid, mn_score, mn_x, mn_y); end total++;
    if (mn_hit !== 1'b1 || mn_count !== 20'd3) begin bad++; $display("FAIL min_hit_count got=%0d/%0d exp=1/3", mn_hit, mn_count); end total++;
    if (best_score !== 21'd9 || best_x !== 10'd0 || hit !== 1'b1) begin bad++; $display("FAIL min_maxside got=%0d@%0d/%0d exp=9@0/1", best_score, best_x, hit); end total++;
    drive(0, 0, 0, '0);
  endtask

  task automatic test_rst_mid_frame();
    drive(1, 0, 0, '0); drive(0, 0, 1, 21'd50);
    rst = 1'b1;
    drive(0, 0, 1, 21'd60);
    rst = 1'b0;
    if (best_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%0d/%0d exp=0/0", best_valid, busy); end total++;
    if (best_score !== 21'd0 || cand_count !== 20'd0 || hit !== 1'b0) begin bad++; $display("FAIL rstmid_clear got=%0d/%0d/%0d exp=0/0/0", best_score, cand_count, hit); end total++;
    drive(0, 1, 0, '0);
    if (best_valid !== 1'b0) begin bad++; $display("FAIL rstmid_noreport got=%0d exp=0", best_valid); end total++;
    threshold = 21'h1FFFFF;
    drive(1, 0, 1, 21'h1FFFFF); drive(0, 0, 1, 21'h1FFFFE); drive(0, 0, 1, 21'd0);
    drive(0, 0, 1, 21'd3); drive(0, 1, 1, 21'h1FFFFF);
    if (best_score !== 21'h1FFFFF || best_x !== 10'd0 || best_y !== 10'd0) begin bad++; $display("FAIL full_best got=%0h@%0d,%0d exp=1fffff@0,0", best_score, best_x, best_y); end total++;
    if (cand_count !== 20'd5 || hit !== 1'b1) begin bad++; $display("FAIL full_count_hit got=%0d/%0d exp=5/1", cand_count, hit); end total++;
    drive(0, 0, 0, '0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_back_to_back();
    test_start_with_score();
    test_abort();
    test_start_end_collision();
    test_empty_and_min();
    test_rst_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
